// File: rtl/piano_pkg.sv
// Shared definitions for the keyboard note-message receiver.
//   MSG_ON_BIT : bit of a note message that selects note-on (1) / note-off (0)
//   NOTE_W     : width of a MIDI note number
//   note_t     : MIDI note number type
//   state_t    : voice allocator FSM states
package piano_pkg;

  localparam int MSG_ON_BIT = 7;
  localparam int NOTE_W     = 7;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/msg_sync_edge.sv
// Strobe receiver front end: brings an asynchronous strobe into the clk domain
// through a SYNC_STAGES flop chain, then flags each rising edge with a
// registered one-cycle pulse.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   din  : asynchronous strobe input
//   rise : one-cycle pulse, registered, after each synchronized 0->1 transition
module msg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      hist <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~hist;
    end
  end

endmodule

// File: rtl/note_voice_alloc.sv
// Receiving end of the keyboard note-message link. Captures each note message
// after its strobe has been synchronized, then maps note-on/note-off messages
// onto NUM_VOICES polyphonic voice slots (retrigger, free slot, or steal oldest).
// Ports:
//   clk          : system clock
//   rst          : asynchronous reset, active-high
//   clk_msg      : message strobe, asynchronous, rising edge = new message
//   msg          : bit7 1=note-on/0=note-off, bits6:0 MIDI note
//   all_off      : synchronous panic, releases every voice
//   voice_active : bit v set while voice v is sounding
//   voice_note   : note of voice v at [7v+6:7v]
//   evt_valid    : one-cycle pulse, a voice changed
//   evt_voice    : voice index qualified by evt_valid
//   evt_on       : 1 = voice started/retriggered, 0 = released
//   overflow     : sticky, a message was lost while busy
module note_voice_alloc
  import piano_pkg::*;
#(
  parameter  int NUM_VOICES  = 4,
  parameter  int AGE_W       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int VIDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_msg,
  input  logic [7:0]                   msg,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic                         evt_valid,
  output logic [VIDX_W-1:0]            evt_voice,
  output logic                         evt_on,
  output logic                         overflow
);

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  state_t            state, state_nx;
  logic              rise;
  logic [7:0]        msg_q, pend_msg;
  logic              pend_vld;
  logic              take;
  logic [7:0]        take_msg;

  logic [VIDX_W-1:0] scan_idx;
  logic              scan_last;
  logic              match_vld, free_vld, old_vld;
  logic [VIDX_W-1:0] match_idx, free_idx, old_idx, tgt;
  logic [AGE_W-1:0]  old_age;

  note_t             note_r [NUM_VOICES];
  logic [AGE_W-1:0]  age_r  [NUM_VOICES];

  logic              cur_act;
  note_t             cur_note;
  logic [AGE_W-1:0]  cur_age;

  logic              evt_vld_p0, evt_on_p0;
  logic [VIDX_W-1:0] evt_voice_p0;

  msg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (clk_msg),
    .rise (rise)
  );

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
    assign voice_note[NOTE_W*g +: NOTE_W] = note_r[g];
  end

  // A held message always goes first so arrival order is preserved.
  assign take      = (state == ST_IDLE) && (pend_vld || rise);
  assign take_msg  = pend_vld ? pend_msg : msg;
  assign scan_last = (scan_idx == VIDX_W'(NUM_VOICES - 1));
  assign cur_act   = voice_active[scan_idx];
  assign cur_note  = note_r[scan_idx];
  assign cur_age   = age_r[scan_idx];

  always_comb begin
    tgt = old_idx;
    if (match_vld)     tgt = match_idx;
    else if (free_vld) tgt = free_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (pend_vld || rise) state_nx = ST_SCAN;
      ST_SCAN:   if (scan_last)        state_nx = ST_COMMIT;
      ST_COMMIT:                       state_nx = ST_IDLE;
      default:                         state_nx = ST_IDLE;
    endcase
    if (all_off) state_nx = ST_IDLE;
  end

  // Pending slot: one message may wait while the allocator is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_msg <= '0;
      overflow <= 1'b0;
    end else if (all_off) begin
      pend_vld <= 1'b0;
    end else if (state == ST_IDLE) begin
      // Pending is consumed now; a simultaneous rise refills the freed slot.
      if (pend_vld) pend_vld <= rise;
      if (pend_vld && rise) pend_msg <= msg;
    end else if (rise) begin
      if (!pend_vld) begin
        pend_msg <= msg;
        pend_vld <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q        <= '0;
      scan_idx     <= '0;
      match_vld    <= 1'b0;
      free_vld     <= 1'b0;
      old_vld      <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      voice_active <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_r[v] <= '0;
        age_r[v]  <= '0;
      end
      evt_vld_p0   <= 1'b0;
      evt_on_p0    <= 1'b0;
      evt_voice_p0 <= '0;
      evt_valid    <= 1'b0;
      evt_on       <= 1'b0;
      evt_voice    <= '0;
    end else begin
      // Stage p0 -> output: event is presented the cycle after the voices update.
      evt_valid  <= evt_vld_p0 & ~all_off;
      evt_on     <= evt_on_p0;
      evt_voice  <= evt_voice_p0;
      evt_vld_p0 <= 1'b0;

      if (all_off) begin
        voice_active <= '0;
        for (int v = 0; v < NUM_VOICES; v++) age_r[v] <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (take) begin
              msg_q     <= take_msg;
              scan_idx  <= '0;
              match_vld <= 1'b0;
              free_vld  <= 1'b0;
              old_vld   <= 1'b0;
            end
          end
          ST_SCAN: begin
            if (cur_act && !match_vld && (cur_note == msg_q[NOTE_W-1:0])) begin
              match_vld <= 1'b1;
              match_idx <= scan_idx;
            end
            if (!cur_act && !free_vld) begin
              free_vld <= 1'b1;
              free_idx <= scan_idx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (cur_act && (!old_vld || (cur_age > old_age))) begin
              old_vld <= 1'b1;
              old_idx <= scan_idx;
              old_age <= cur_age;
            end
            scan_idx <= scan_idx + 1'b1;
          end
          ST_COMMIT: begin
            if (msg_q[MSG_ON_BIT]) begin
              for (int v = 0; v < NUM_VOICES; v++) begin
                if (VIDX_W'(v) == tgt) begin
                  note_r[v]       <= msg_q[NOTE_W-1:0];
                  voice_active[v] <= 1'b1;
                  age_r[v]        <= '0;
                end else if (voice_active[v]) begin
                  age_r[v] <= sat_inc(age_r[v]);
                end
              end
              evt_vld_p0   <= 1'b1;
              evt_on_p0    <= 1'b1;
              evt_voice_p0 <= tgt;
            end else if (match_vld) begin
              voice_active[match_idx] <= 1'b0;
              age_r[match_idx]        <= '0;
              evt_vld_p0              <= 1'b1;
              evt_on_p0               <= 1'b0;
              evt_voice_p0            <= match_idx;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_voice_alloc.sv
module tb_note_voice_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_msg = 1'b0;
  logic [7:0]  msg = 8'h00;
  logic        all_off = 1'b0;
  logic [3:0]  voice_active;
  logic [27:0] voice_note;
  logic        evt_valid;
  logic [1:0]  evt_voice;
  logic        evt_on;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  note_voice_alloc #(.NUM_VOICES(4), .AGE_W(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_msg      (clk_msg),
    .msg          (msg),
    .all_off      (all_off),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .evt_valid    (evt_valid),
    .evt_voice    (evt_voice),
    .evt_on       (evt_on),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_msg = 1'b0; msg = 8'h00; all_off = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Raises the strobe with message m and measures clk edges from the first
  // edge that samples it high to the edge after which evt_valid is seen.
  task automatic note_evt(input logic [7:0] m, output int lat, output logic [1:0] v,
                          output logic on, output logic again);
    @(negedge clk);
    msg = m; clk_msg = 1'b1;
    lat = -1; v = 2'd0; on = 1'b0; again = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (evt_valid) begin
        lat = k; v = evt_voice; on = evt_on;
        @(posedge clk); #1;
        again = evt_valid;
        break;
      end
    end
    @(negedge clk);
    clk_msg = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic count_evt(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (evt_valid) c++;
    end
  endtask

  initial begin
    int         lat;
    int         cnt;
    logic [1:0] v;
    logic       on;
    logic       again;
    logic [7:0] seq [5];
    int         exp_v [5];

    seq   = '{8'hBC, 8'hBE, 8'hC0, 8'hC1, 8'hC3};
    exp_v = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    check("rst_active_held", 32'(voice_active), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_active", 32'(voice_active), 32'h0);
    check("rst_note",   32'(voice_note),   32'h0);
    check("rst_evt",    32'(evt_valid),    32'h0);
    check("rst_ovf",    32'(overflow),     32'h0);

    // 1: single note-on after reset
    note_evt(8'hBC, lat, v, on, again);
    check("t1_latency",  32'(lat), 32'd9);
    check("t1_voice",    32'(v),   32'd0);
    check("t1_on",       32'(on),  32'd1);
    check("t1_pulse",    32'(again), 32'd0);
    check("t1_active",   32'(voice_active), 32'h1);
    check("t1_note0",    32'(voice_note[6:0]), 32'd60);

    // 2: fill all voices, fifth note steals the oldest (voice 0)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      note_evt(seq[i], lat, v, on, again);
      check($sformatf("t2_lat_%0d", i),   32'(lat), 32'd9);
      check($sformatf("t2_voice_%0d", i), 32'(v),   32'(exp_v[i]));
    end
    check("t2_active", 32'(voice_active), 32'hF);
    check("t2_notes",  32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd67}));

    // 3: retrigger the same note
    do_reset();
    note_evt(8'hBC, lat, v, on, again);
    note_evt(8'hBC, lat, v, on, again);
    check("t3_lat",    32'(lat), 32'd9);
    check("t3_voice",  32'(v),   32'd0);
    check("t3_on",     32'(on),  32'd1);
    check("t3_active", 32'(voice_active), 32'h1);

    // 4: note-off of a held note, then of a note not held
    do_reset();
    note_evt(8'hBC, lat, v, on, again);
    note_evt(8'h3C, lat, v, on, again);
    check("t4_off_lat",    32'(lat), 32'd9);
    check("t4_off_voice",  32'(v),   32'd0);
    check("t4_off_on",     32'(on),  32'd0);
    check("t4_off_active", 32'(voice_active), 32'h0);
    note_evt(8'h40, lat, v, on, again);
    check("t4_noheld_noevt", 32'(lat), 32'hFFFFFFFF);
    check("t4_ovf",          32'(overflow), 32'h0);

    // 5: three strobes two clocks apart; third is dropped
    do_reset();
    @(negedge clk);
    msg = 8'hBC;
    for (int i = 0; i < 3; i++) begin
      clk_msg = 1'b1;
      @(negedge clk);
      clk_msg = 1'b0;
      @(negedge clk);
    end
    count_evt(40, cnt);
    check("t5_evt_count", 32'(cnt), 32'd2);
    check("t5_overflow",  32'(overflow), 32'h1);
    check("t5_active",    32'(voice_active), 32'h1);

    // 6a: all_off during the scan of a note-on with three voices held
    do_reset();
    note_evt(8'hBC, lat, v, on, again);
    note_evt(8'hBE, lat, v, on, again);
    note_evt(8'hC0, lat, v, on, again);
    check("t6_pre_active", 32'(voice_active), 32'h7);
    @(negedge clk);
    msg = 8'hBE; clk_msg = 1'b1;
    repeat (5) @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0; clk_msg = 1'b0;
    count_evt(25, cnt);
    check("t6_alloff_noevt",  32'(cnt), 32'd0);
    check("t6_alloff_active", 32'(voice_active), 32'h0);

    // 6b: reset asserted mid-scan clears everything at once
    note_evt(8'hBC, lat, v, on, again);
    check("t6_post_lat", 32'(lat), 32'd9);
    @(negedge clk);
    msg = 8'hBE; clk_msg = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; clk_msg = 1'b0;
    #1;
    check("t6_rst_active", 32'(voice_active), 32'h0);
    check("t6_rst_note",   32'(voice_note),   32'h0);
    check("t6_rst_evt",    32'(evt_valid),    32'h0);
    check("t6_rst_ovf",    32'(overflow),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    count_evt(25, cnt);
    check("t6_rst_noevt",  32'(cnt), 32'd0);
    check("t6_rst_idle_active", 32'(voice_active), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
